piso_serializer: RTL and testbench
==================================

// Module: piso_serializer
// PURPOSE
// - Parallel-in/serial-out transmitter; upstream neighbour of the 10-bit sipo deserializer.
// - Accepts WIDTH-bit words over a valid/ready handshake and shifts them onto one serial line, one bit per clk.
// - Back-to-back words produce a gap-free bit stream, so the sipo can recover words from a continuous line.
// PARAMETERS
// - WIDTH      10             bits per word
// - LSB_FIRST  1              1: bit 0 sent first; 0: bit WIDTH-1 sent first
// - COMMA      10'b0011111010 idle filler word (K28.5, RD-); used only with PISO_IDLE_COMMA_EN
// PORTS
// - clk           in   1      single clock, all state updates on rising edge
// - reinicio      in   1      asynchronous, active-low reset
// - data_in       in   WIDTH  word to send; sampled only on the accept edge
// - data_valid    in   1      data_in holds a word; must stay high, data_in stable, until accepted
// - data_ready    out  1      combinational: block accepts data_in at the next rising edge
// - serial_out    out  1      registered serial bit
// - serial_valid  out  1      registered: serial_out carries a word or comma bit
// - word_start    out  1      registered: high with the first bit of every word or comma
// - comma_out     out  1      registered: current word is filler; tied 0 without PISO_IDLE_COMMA_EN
// BEHAVIOUR
// - Reset (reinicio=0, asynchronous):
//   - state=IDLE, shift register and bit counter cleared.
//   - serial_out, serial_valid, word_start, comma_out = 0.
//   - data_ready forced 0 while reinicio=0.
// - Reset mid-word aborts the word: no partial resume; the word is lost and must be re-offered.
// - Accept = data_valid & data_ready at a rising edge.
// - States:
//   - IDLE: data_ready=1. Accept -> SHIFT, load data_in, cnt=0.
//   - SHIFT: cnt increments 0..WIDTH-1 each cycle; data_ready=1 only at cnt==WIDTH-1.
//     - At cnt==WIDTH-1 with accept: reload, cnt=0, stay in SHIFT. This gives zero gap.
//     - At cnt==WIDTH-1 without accept: -> IDLE.
// - Latency: the first bit of a word is on serial_out in the cycle after its accept edge.
//   word_start=1 in that cycle only; serial_valid=1 for exactly WIDTH cycles per word.
// - Bit order: LSB_FIRST=1 gives data_in[0], [1], ... [WIDTH-1]; LSB_FIRST=0 gives the reverse.
// - Throughput: 1 word per WIDTH cycles maximum.
// - data_valid while data_ready=0 is held off with no effect.
// - data_in changes while not being accepted are ignored.
// - In IDLE without the macro: serial_out=0, serial_valid=0.
// CONFIGURATION
// - PISO_IDLE_COMMA_EN defined:
//   - At any word boundary (IDLE, or cnt==WIDTH-1) with data_valid=0, COMMA is loaded instead.
//   - Comma words drive word_start, serial_valid=1, and comma_out=1 for all WIDTH bits.
//   - IDLE is transient: it lasts only the first cycle after reset release.
//   - Data arriving mid-comma waits for the comma boundary (at most WIDTH-1 cycles).
//   - Data has priority over comma at a boundary.
// - PISO_IDLE_COMMA_EN undefined:
//   - No filler; the line idles at 0 with serial_valid=0.
//   - comma_out is constant 0.
// TESTING (WIDTH=10, LSB_FIRST=1)
// - Single word: accept 10'h2B5 -> serial_out 1,0,1,0,1,1,0,1,0,1 on the next 10 cycles.
//   word_start only on the 1st; serial_valid 10 cycles, then 0.
// - Back-to-back: 10'h2B5 then 10'h155 held valid -> 20 contiguous valid bits.
//   word_start at bit cycles 1 and 11; data_ready high exactly at the two boundary cycles.
// - Backpressure: raise data_valid at cnt=3 of a word -> no accept until cnt==9.
//   The new word starts with no gap; data_in is sampled only at that edge.
// - Reset mid-word: drop reinicio at bit 5 of 10'h3FF -> all outputs 0 immediately.
//   After release, data_ready=1 and the line stays idle with no residual bits.
// - PISO_IDLE_COMMA_EN, no data after reset -> repeating 0,1,0,1,1,1,1,1,0,0 with comma_out=1.
//   Valid 10'h2B5 raised mid-comma -> starts right after the comma ends, comma_out=0.
// - Without the macro, idle 30 cycles -> serial_out=0, serial_valid=0, comma_out=0 throughout.

Source files
------------

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter: valid/ready word intake, one bit per clk, gap-free back-to-back.
// Optional build macro PISO_IDLE_COMMA_EN fills idle word slots with the COMMA word.
`timescale 1ns/1ps

module piso_serializer #(
    parameter int               WIDTH     = 10,
    parameter int               LSB_FIRST = 1,
    parameter logic [WIDTH-1:0] COMMA     = 10'b0011111010
) (
    input  logic             clk,
    input  logic             reinicio,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             word_start,
    output logic             comma_out
);

    localparam int               CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state, next_state;
    logic [CNT_W-1:0] cnt, next_cnt;
    logic [WIDTH-1:0] sreg, next_sreg;
    logic             next_serial, next_valid, next_start, next_comma;
    logic [WIDTH-1:0] load_word;
    logic             boundary, accept, load_comma, load;

    // cnt is the index of the bit currently on serial_out, so the last bit's cycle is the reload slot.
    assign boundary   = (state == IDLE) || (cnt == LAST);
    assign data_ready = reinicio && boundary;
    assign accept     = data_valid && data_ready;

`ifdef PISO_IDLE_COMMA_EN
    assign load_comma = boundary && !data_valid;
`else
    assign load_comma = 1'b0;
`endif

    assign load = accept || load_comma;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        next_state  = state;
        next_cnt    = cnt;
        next_sreg   = sreg;
        next_serial = 1'b0;
        next_valid  = 1'b0;
        next_start  = 1'b0;
        next_comma  = 1'b0;
        load_word   = load_comma ? COMMA : data_in;

        if (load) begin
            next_state = SHIFT;
            next_cnt   = '0;
            next_valid = 1'b1;
            next_start = 1'b1;
            next_comma = load_comma;
            if (LSB_FIRST != 0) begin
                next_serial = load_word[0];
                next_sreg   = load_word >> 1;
            end else begin
                next_serial = load_word[WIDTH-1];
                next_sreg   = load_word << 1;
            end
        end else if (state == SHIFT && cnt != LAST) begin
            next_cnt   = cnt + CNT_W'(1);
            next_valid = 1'b1;
            next_comma = comma_out;
            if (LSB_FIRST != 0) begin
                next_serial = sreg[0];
                next_sreg   = sreg >> 1;
            end else begin
                next_serial = sreg[WIDTH-1];
                next_sreg   = sreg << 1;
            end
        end else begin
            // Last bit sent with nothing to follow: drop back to an idle line.
            next_state = IDLE;
            next_cnt   = '0;
            next_sreg  = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge reinicio) begin
        if (!reinicio) begin
            state        <= IDLE;
            cnt          <= '0;
            sreg         <= '0;
            serial_out   <= 1'b0;
            serial_valid <= 1'b0;
            word_start   <= 1'b0;
            comma_out    <= 1'b0;
        end else begin
            state        <= next_state;
            cnt          <= next_cnt;
            sreg         <= next_sreg;
            serial_out   <= next_serial;
            serial_valid <= next_valid;
            word_start   <= next_start;
            comma_out    <= next_comma;
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed self-checking bench for piso_serializer (WIDTH=10, LSB_FIRST=1).
// Build with PISO_IDLE_COMMA_EN defined to exercise the comma-filler variant.
`timescale 1ns/1ps

module tb_piso_serializer;

    logic       clk = 1'b0;
    logic       reinicio;
    logic [9:0] data_in;
    logic       data_valid;
    logic       data_ready, serial_out, serial_valid, word_start, comma_out;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [9:0] COMMA_W = 10'b0011111010;

    piso_serializer #(.WIDTH(10), .LSB_FIRST(1)) dut (
        .clk          (clk),
        .reinicio     (reinicio),
        .data_in      (data_in),
        .data_valid   (data_valid),
        .data_ready   (data_ready),
        .serial_out   (serial_out),
        .serial_valid (serial_valid),
        .word_start   (word_start),
        .comma_out    (comma_out)
    );

    always #5 clk = ~clk;

    // Observed vector: {serial_out, serial_valid, word_start, comma_out, data_ready}
    function automatic logic [4:0] obs();
        return {serial_out, serial_valid, word_start, comma_out, data_ready};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [4:0] exp;
        reinicio   = 1'b0;
        data_valid = 1'b0;
        data_in    = '0;
        #3;
        exp = 5'b00000;
        n_checks++;
        if (obs() !== exp) begin
            n_fail++;
            $display("FAIL reset_initial: got %b want %b", obs(), exp);
        end
        data_valid = 1'b1;
        data_in    = 10'h2B5;
        repeat (3) tick();
        n_checks++;
        if (obs() !== exp) begin
            n_fail++;
            $display("FAIL reset_held_valid: got %b want %b", obs(), exp);
        end
        data_valid = 1'b0;
        @(negedge clk);
        reinicio = 1'b1;
        #1;
        exp = 5'b00001;
        n_checks++;
        if (obs() !== exp) begin
            n_fail++;
            $display("FAIL reset_release: got %b want %b", obs(), exp);
        end
    endtask

    task automatic test_single_word();
        logic [9:0] w;
        logic [4:0] exp;
        w          = 10'h2B5;
        data_in    = w;
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        data_in    = 10'h3C3;
        for (int i = 0; i < 10; i++) begin
            exp = {w[i], 1'b1, (i == 0), 1'b0, (i == 9)};
            n_checks++;
            if (obs() !== exp) begin
                n_fail++;
                $display("FAIL single_bit%0d: got %b want %b", i, obs(), exp);
            end
            tick();
        end
        exp = 5'b00001;
        n_checks++;
        if (obs() !== exp) begin
            n_fail++;
            $display("FAIL single_after: got %b want %b", obs(), exp);
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] w0, w1, w;
        logic [4:0] exp;
        w0         = 10'h2B5;
        w1         = 10'h155;
        data_in    = w0;
        data_valid = 1'b1;
        tick();
        data_in = w1;
        for (int i = 0; i < 20; i++) begin
            if (i == 10) data_valid = 1'b0;
            w   = (i < 10) ? w0 : w1;
            exp = {w[i % 10], 1'b1, (i % 10 == 0), 1'b0, (i % 10 == 9)};
            n_checks++;
            if (obs() !== exp) begin
                n_fail++;
                $display("FAIL b2b_bit%0d: got %b want %b", i, obs(), exp);
            end
            tick();
        end
        exp = 5'b00001;
        n_checks++;
        if (obs() !== exp) begin
            n_fail++;
            $display("FAIL b2b_after: got %b want %b", obs(), exp);
        end
    endtask

    task automatic test_backpressure();
        logic [9:0] w0, w1, w;
        logic [4:0] exp;
        w0         = 10'h2B5;
        w1         = 10'h0F1;
        data_in    = w0;
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        data_in    = 10'h3C3;
        for (int i = 0; i < 20; i++) begin
            if (i == 3) begin
                data_in    = w1;
                data_valid = 1'b1;
            end
            if (i == 10) begin
                data_valid = 1'b0;
                data_in    = 10'h000;
            end
            w   = (i < 10) ? w0 : w1;
            exp = {w[i % 10], 1'b1, (i % 10 == 0), 1'b0, (i % 10 == 9)};
            n_checks++;
            if (obs() !== exp) begin
                n_fail++;
                $display("FAIL bp_bit%0d: got %b want %b", i, obs(), exp);
            end
            tick();
        end
        exp = 5'b00001;
        n_checks++;
        if (obs() !== exp) begin
            n_fail++;
            $display("FAIL bp_after: got %b want %b", obs(), exp);
        end
    endtask

    task automatic test_reset_mid_word();
        logic [4:0] exp;
        data_in    = 10'h3FF;
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            exp = {1'b1, 1'b1, (i == 0), 1'b0, 1'b0};
            n_checks++;
            if (obs() !== exp) begin
                n_fail++;
                $display("FAIL rst_mid_bit%0d: got %b want %b", i, obs(), exp);
            end
            if (i < 5) tick();
        end
        #2 reinicio = 1'b0;
        #1;
        exp = 5'b00000;
        n_checks++;
        if (obs() !== exp) begin
            n_fail++;
            $display("FAIL rst_mid_async: got %b want %b", obs(), exp);
        end
        tick();
        @(negedge clk);
        reinicio = 1'b1;
        #1;
        exp = 5'b00001;
        n_checks++;
        if (obs() !== exp) begin
            n_fail++;
            $display("FAIL rst_mid_release: got %b want %b", obs(), exp);
        end
        for (int i = 0; i < 12; i++) begin
            tick();
            n_checks++;
            if (obs() !== exp) begin
                n_fail++;
                $display("FAIL rst_mid_idle%0d: got %b want %b", i, obs(), exp);
            end
        end
    endtask

    task automatic test_idle();
        logic [4:0] exp;
        data_valid = 1'b0;
        exp        = 5'b00001;
        for (int i = 0; i < 30; i++) begin
            tick();
            n_checks++;
            if (obs() !== exp) begin
                n_fail++;
                $display("FAIL idle%0d: got %b want %b", i, obs(), exp);
            end
        end
    endtask

    task automatic test_comma();
        logic [9:0] w, c;
        logic [4:0] exp;
        c          = COMMA_W;
        w          = 10'h2B5;
        data_valid = 1'b0;
        tick();
        for (int i = 0; i < 30; i++) begin
            if (i == 23) begin
                data_in    = w;
                data_valid = 1'b1;
            end
            exp = {c[i % 10], 1'b1, (i % 10 == 0), 1'b1, (i % 10 == 9)};
            n_checks++;
            if (obs() !== exp) begin
                n_fail++;
                $display("FAIL comma_bit%0d: got %b want %b", i, obs(), exp);
            end
            tick();
        end
        data_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            exp = {w[i], 1'b1, (i == 0), 1'b0, (i == 9)};
            n_checks++;
            if (obs() !== exp) begin
                n_fail++;
                $display("FAIL comma_data_bit%0d: got %b want %b", i, obs(), exp);
            end
            tick();
        end
        exp = {c[0], 1'b1, 1'b1, 1'b1, 1'b0};
        n_checks++;
        if (obs() !== exp) begin
            n_fail++;
            $display("FAIL comma_resume: got %b want %b", obs(), exp);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
`ifdef PISO_IDLE_COMMA_EN
        test_comma();
`else
        test_idle();
        test_single_word();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_word();
        test_idle();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
